// File: rtl/change_pkg.sv
// Shared coin constants, one-hot coin encoding and FSM state type for the change dispenser.
package change_pkg;

    localparam logic [7:0] COIN_100 = 8'd100;
    localparam logic [7:0] COIN_50  = 8'd50;
    localparam logic [7:0] COIN_10  = 8'd10;
    localparam logic [7:0] COIN_5   = 8'd5;

    // One-hot coin select order: {dollar, fifty, ten, five}
    localparam logic [3:0] SEL_100 = 4'b1000;
    localparam logic [3:0] SEL_50  = 4'b0100;
    localparam logic [3:0] SEL_10  = 4'b0010;
    localparam logic [3:0] SEL_5   = 4'b0001;
    localparam logic [3:0] SEL_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_GAP      = 2'd2,
        ST_FINISH   = 2'd3
    } state_t;

    function automatic logic is_mult5(input logic [7:0] v);
        return (v % 8'd5) == 8'd0;
    endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: largest coin not exceeding the remaining amount, zero when nothing fits.
module coin_select
    import change_pkg::*;
(
    input  logic [7:0] remaining,
    output logic [3:0] coin_sel,
    output logic [7:0] coin_val
);

    always_comb begin
        coin_sel = SEL_NONE;
        coin_val = 8'd0;
        if (remaining >= COIN_100) begin
            coin_sel = SEL_100;
            coin_val = COIN_100;
        end else if (remaining >= COIN_50) begin
            coin_sel = SEL_50;
            coin_val = COIN_50;
        end else if (remaining >= COIN_10) begin
            coin_sel = SEL_10;
            coin_val = COIN_10;
        end else if (remaining >= COIN_5) begin
            coin_sel = SEL_5;
            coin_val = COIN_5;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser FSM: pays out an amount as 100/50/10/5-cent coin pulses.
// Define DISPENSE_GAP_EN to insert one idle GAP cycle after every coin pulse.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for Start; Ready high once settled for a cycle
// ST_DISPENSE | one coin pulse per cycle, remaining reduced by coin value
// ST_GAP      | coin outputs low between pulses (DISPENSE_GAP_EN only)
// ST_FINISH   | next edge pulses Done (or Error for bad amount), back to IDLE
module change_dispenser
    import change_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic [7:0] Amount,
    output logic       Ready,
    output logic       OneDollarOut,
    output logic       FiftyCentsOut,
    output logic       TenCentsOut,
    output logic       FiveCentsOut,
    output logic       Done,
    output logic       Error
);

    state_t     state;
    logic [7:0] remaining;
    logic       err_pend;
    logic [3:0] coin_sel;
    logic [7:0] coin_val;
    logic [7:0] rem_next;
    logic       last_coin;

    coin_select u_coin_select (
        .remaining (remaining),
        .coin_sel  (coin_sel),
        .coin_val  (coin_val)
    );

    // coin_val never exceeds remaining, so this cannot wrap
    assign rem_next  = remaining - coin_val;
    assign last_coin = (rem_next == 8'd0) || (coin_val == 8'd0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= ST_IDLE;
            remaining     <= 8'd0;
            err_pend      <= 1'b0;
            Ready         <= 1'b1;
            OneDollarOut  <= 1'b0;
            FiftyCentsOut <= 1'b0;
            TenCentsOut   <= 1'b0;
            FiveCentsOut  <= 1'b0;
            Done          <= 1'b0;
            Error         <= 1'b0;
        end else begin
            OneDollarOut  <= 1'b0;
            FiftyCentsOut <= 1'b0;
            TenCentsOut   <= 1'b0;
            FiveCentsOut  <= 1'b0;
            Done          <= 1'b0;
            Error         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!Ready) begin
                        Ready <= 1'b1;
                    end else if (Start) begin
                        Ready <= 1'b0;
                        if (!is_mult5(Amount)) begin
                            err_pend  <= 1'b1;
                            remaining <= 8'd0;
                            state     <= ST_FINISH;
                        end else begin
                            err_pend  <= 1'b0;
                            remaining <= Amount;
                            state     <= (Amount == 8'd0) ? ST_FINISH : ST_DISPENSE;
                        end
                    end
                end
                ST_DISPENSE: begin
                    {OneDollarOut, FiftyCentsOut, TenCentsOut, FiveCentsOut} <= coin_sel;
                    remaining <= last_coin ? 8'd0 : rem_next;
`ifdef DISPENSE_GAP_EN
                    state <= ST_GAP;
`else
                    state <= last_coin ? ST_FINISH : ST_DISPENSE;
`endif
                end
                ST_GAP: begin
                    state <= (remaining == 8'd0) ? ST_FINISH : ST_DISPENSE;
                end
                ST_FINISH: begin
                    if (err_pend) begin
                        Error <= 1'b1;
                    end else begin
                        Done <= 1'b1;
                    end
                    err_pend <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: arithmetic payout model plus directed literal checks.
module tb_change_dispenser;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] Amount = 8'd0;
    logic       Ready, OneDollarOut, FiftyCentsOut, TenCentsOut, FiveCentsOut, Done, Error;

    change_dispenser dut (
        .CLK           (CLK),
        .RST           (RST),
        .Start         (Start),
        .Amount        (Amount),
        .Ready         (Ready),
        .OneDollarOut  (OneDollarOut),
        .FiftyCentsOut (FiftyCentsOut),
        .TenCentsOut   (TenCentsOut),
        .FiveCentsOut  (FiveCentsOut),
        .Done          (Done),
        .Error         (Error)
    );

    always #5 CLK = ~CLK;

    // {Ready, dollar, fifty, ten, five, Done, Error}
    logic [6:0] outs;
    assign outs = {Ready, OneDollarOut, FiftyCentsOut, TenCentsOut, FiveCentsOut, Done, Error};

    localparam logic [6:0] V_IDLE = 7'b1000000;
    localparam logic [6:0] V_ZERO = 7'b0000000;
    localparam logic [6:0] V_100  = 7'b0100000;
    localparam logic [6:0] V_50   = 7'b0010000;
    localparam logic [6:0] V_10   = 7'b0001000;
    localparam logic [6:0] V_5    = 7'b0000100;
    localparam logic [6:0] V_DONE = 7'b0000010;
    localparam logic [6:0] V_ERR  = 7'b0000001;

`ifdef DISPENSE_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: on accept, the whole per-cycle output schedule is laid out by greedy arithmetic.
    logic [6:0] q[$];
    logic [6:0] exp_cur = V_IDLE;

    function automatic void build(input int amt);
        int vals[4] = '{100, 50, 10, 5};
        logic [6:0] bits[4] = '{V_100, V_50, V_10, V_5};
        int r = amt;
        q.push_back(V_ZERO);
        if (amt % 5 != 0) begin
            q.push_back(V_ERR);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            while (r >= vals[i]) begin
                q.push_back(bits[i]);
                if (GAP) q.push_back(V_ZERO);
                r -= vals[i];
            end
        end
        q.push_back(V_DONE);
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            q.delete();
            exp_cur = V_IDLE;
        end else begin
            if (exp_cur[6] && Start) build(int'(Amount));
            if (q.size() > 0) exp_cur = q.pop_front();
            else exp_cur = V_IDLE;
        end
    end

    initial begin
        wait (cmp_en);
        forever begin
            @(negedge CLK);
            if (cmp_en) check("cycle", int'(outs), int'(exp_cur));
        end
    end

    logic [6:0] trace[0:15];

    task automatic wait_ready();
        int i = 0;
        while (!Ready && i < 50) begin
            @(negedge CLK);
            i++;
        end
        if (!Ready) check("ready_timeout", int'(Ready), 1);
    endtask

    task automatic run_req(input logic [7:0] amt, input int ncyc, input bit hold);
        wait_ready();
        Start  = 1'b1;
        Amount = amt;
        @(posedge CLK);
        @(negedge CLK);
        if (!hold) Start = 1'b0;
        trace[0] = outs;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge CLK);
            trace[k] = outs;
        end
        Start = 1'b0;
    endtask

    function automatic int count_bits(input int lo, input int hi, input logic [6:0] mask);
        int n = 0;
        for (int k = lo; k <= hi; k++) n += $countones(trace[k] & mask);
        return n;
    endfunction

    initial begin
        logic [7:0] sweep[10] = '{8'd5, 8'd10, 8'd15, 8'd95, 8'd100, 8'd105, 8'd150, 8'd250, 8'd0, 8'd13};
        logic [5:0] seen;

        RST = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK);
        check("reset_state", int'(outs), int'(V_IDLE));
        cmp_en = 1'b1;

`ifndef DISPENSE_GAP_EN
        run_req(8'd65, 6, 1'b0);
        check("a65_n0", int'(trace[0]), int'(V_ZERO));
        check("a65_n1_fifty", int'(trace[1]), int'(V_50));
        check("a65_n2_ten", int'(trace[2]), int'(V_10));
        check("a65_n3_five", int'(trace[3]), int'(V_5));
        check("a65_n4_done", int'(trace[4]), int'(V_DONE));
        check("a65_n5_ready", int'(trace[5]), int'(V_IDLE));

        run_req(8'd255, 7, 1'b0);
        check("a255_n1", int'(trace[1]), int'(V_100));
        check("a255_n2", int'(trace[2]), int'(V_100));
        check("a255_n3", int'(trace[3]), int'(V_50));
        check("a255_n4", int'(trace[4]), int'(V_5));
        check("a255_n5_done", int'(trace[5]), int'(V_DONE));
        check("a255_coin_count", count_bits(0, 7, 7'b0111100), 4);
`else
        run_req(8'd200, 6, 1'b0);
        check("g200_n1", int'(trace[1]), int'(V_100));
        check("g200_n2_gap", int'(trace[2]), int'(V_ZERO));
        check("g200_n3", int'(trace[3]), int'(V_100));
        check("g200_n4_gap", int'(trace[4]), int'(V_ZERO));
        check("g200_n5_done", int'(trace[5]), int'(V_DONE));
`endif

        run_req(8'd0, 3, 1'b0);
        check("a0_n1_done", int'(trace[1]), int'(V_DONE));
        check("a0_n2_ready", int'(trace[2]), int'(V_IDLE));

        run_req(8'd37, 4, 1'b0);
        check("a37_n1_error", int'(trace[1]), int'(V_ERR));
        check("a37_n2_ready", int'(trace[2]), int'(V_IDLE));
        check("a37_no_done", count_bits(0, 4, V_DONE), 0);

        // Reset in the middle of a 200-cent payout
        wait_ready();
        Start  = 1'b1;
        Amount = 8'd200;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        @(negedge CLK);
        check("r200_first_dollar", int'(outs), int'(V_100));
        #2 RST = 1'b0;
        #1 check("r200_async_reset", int'(outs), int'(V_IDLE));
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        seen = '0;
        repeat (8) begin
            @(negedge CLK);
            seen |= outs[5:0];
        end
        check("r200_no_pulse_after", int'(seen), 0);
        check("r200_ready_after", int'(Ready), 1);

        // Start held through a whole 150-cent payout
        run_req(8'd150, 6, 1'b1);
        check("h150_single_done", count_bits(0, 6, V_DONE), 1);
`ifndef DISPENSE_GAP_EN
        check("h150_n1", int'(trace[1]), int'(V_100));
        check("h150_n2", int'(trace[2]), int'(V_50));
        check("h150_n3_done", int'(trace[3]), int'(V_DONE));
        check("h150_n4_ready", int'(trace[4]), int'(V_IDLE));
        check("h150_n5_reaccept", int'(trace[5]), int'(V_ZERO));
        check("h150_n6_dollar", int'(trace[6]), int'(V_100));
`endif

        foreach (sweep[i]) run_req(sweep[i], 2, 1'b0);
        wait_ready();
        repeat (3) @(negedge CLK);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have port CLK, input, 1 bit, single system clock, rising-edge active.
REQ-002 SHALL have port RST, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have port Start, input, 1 bit, request to dispense Amount; accepted only while Ready=1.
REQ-004 SHALL have port Amount, input, 8 bits, change to return in cents (0..255), sampled on accept.
REQ-005 SHALL have port Ready, output, 1 bit, high only in IDLE.
REQ-006 SHALL have port OneDollarOut, output, 1 bit, one-cycle pulse per 100-cent coin.
REQ-007 SHALL have port FiftyCentsOut, output, 1 bit, one-cycle pulse per 50-cent coin.
REQ-008 SHALL have port TenCentsOut, output, 1 bit, one-cycle pulse per 10-cent coin.
REQ-009 SHALL have port FiveCentsOut, output, 1 bit, one-cycle pulse per 5-cent coin.
REQ-010 SHALL have port Done, output, 1 bit, one-cycle pulse when a request completes.
REQ-011 SHALL have port Error, output, 1 bit, one-cycle pulse when Amount is not a multiple of 5.

Function
REQ-012 SHALL implement FSM states IDLE, DISPENSE, GAP, FINISH; all outputs registered.
REQ-013 Accept = Start&&Ready at edge N: remaining <= Amount; next state DISPENSE, or FINISH if Amount==0.
REQ-014 Accept with Amount%5!=0: SHALL pulse Error at edge N+1, dispense no coins, no Done, return to IDLE.
REQ-015 Each DISPENSE edge SHALL assert exactly one coin output for one cycle: largest coin <= remaining (100>50>10>5); remaining -= coin value.
REQ-016 First coin SHALL be visible after edge N+1; at most one coin output high in any cycle.
REQ-017 When remaining reaches 0, next state SHALL be FINISH; Done SHALL pulse on the following edge with all coin outputs low; then IDLE.
REQ-018 Start while Ready=0 SHALL be ignored, not queued.
REQ-019 Amount 0 SHALL produce Done at edge N+1 with no coins.
REQ-020 Remaining arithmetic SHALL be 8-bit unsigned and never underflow.

Reset
REQ-021 RST low SHALL immediately force IDLE, remaining=0, Ready=1, all coin outputs, Done and Error 0, including mid-dispense.
REQ-022 An interrupted request SHALL be discarded; no Done after reset release.

Configuration
REQ-023 Macro DISPENSE_GAP_EN defined: after every coin pulse, FSM SHALL spend one GAP cycle (all coin outputs low) before the next DISPENSE; GAP before FINISH too.
REQ-024 DISPENSE_GAP_EN undefined: GAP state unreachable; coins emitted back-to-back each cycle.

Structure
REQ-025 Package change_pkg SHALL hold coin value constants (100, 50, 10, 5) and the FSM state type.
REQ-026 Sub-module coin_select SHALL be combinational: remaining in, one-hot coin select and coin value out.

Verification
REQ-027 Amount=65, no gap -> FiftyCentsOut, TenCentsOut, FiveCentsOut on consecutive cycles from N+1, Done at N+4.
REQ-028 Amount=255 -> OneDollarOut x2, FiftyCentsOut, FiveCentsOut; Done at N+5; exactly 4 coin pulses.
REQ-029 Amount=0 -> no coins, Done at N+1; Amount=37 -> Error at N+1, no Done, Ready at N+2.
REQ-030 Amount=200, RST low after first OneDollarOut -> no further pulses, Ready=1, Done never asserted.
REQ-031 DISPENSE_GAP_EN, Amount=200 -> OneDollarOut at N+1 and N+3, low at N+2, Done at N+5.
REQ-032 Start held high during dispensing of 150 -> exactly one request serviced, then re-accepted only when Ready=1.
